ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator for the single-port tri-state-bus RAM (ena/wena/addr/inout data, 32x32).
//  Accepts single or burst requests on a valid/ready port and sequences RAM cycles.
//  Drives the shared data bus only on writes and inserts bus turnaround after reads.
//  Returns read data on a response strobe. Sits between the test/control logic and the RAM.
// PARAMETERS
//  ADDR_W  5   RAM address width; RAM depth = 2**ADDR_W
//  DATA_W  32  data bus width
// PORTS
//  clk        in    1       single clock, all logic on posedge
//  rst_n      in    1       asynchronous, active-low reset
//  req_valid  in    1       request present
//  req_ready  out   1       block can accept a request (IDLE)
//  req_write  in    1       1 = fill-write burst, 0 = read burst
//  req_addr   in    ADDR_W  first address of burst
//  req_len    in    ADDR_W  beats minus one (0 -> 1 beat, 31 -> 32 beats)
//  req_wdata  in    DATA_W  value written to every beat of a write burst
//  rsp_valid  out   1       one-cycle strobe: rsp_rdata/rsp_addr valid
//  rsp_rdata  out   DATA_W  read data
//  rsp_addr   out   ADDR_W  address rsp_rdata came from
//  done       out   1       one-cycle strobe: burst complete
//  ram_ena    out   1       to RAM ena
//  ram_wena   out   1       to RAM wena
//  ram_addr   out   ADDR_W  to RAM addr
//  ram_data   inout DATA_W  shared RAM data bus; driven only while in WRITE, else 'z
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; ram_ena=0, ram_wena=0, ram_addr=0, bus released;
//    rsp_valid=0, rsp_rdata=0, rsp_addr=0, done=0; any burst in flight is abandoned.
//  - All RAM-side outputs and the bus drive enable are registered. No combinational path to RAM.
//  - req_ready = (state==IDLE). Handshake on posedge with req_valid&req_ready; request fields
//    captured then. Requests are not queued; req_* is ignored outside IDLE.
//  - States: IDLE, WRITE, READ_REQ, READ_CAP.
//  - Write burst: accept at edge E0 -> WRITE: ena=1, wena=1, addr=A, bus=req_wdata.
//    One beat per cycle; the RAM writes at E1..E(len+1), addr increments each edge.
//    After the last beat edge: ena=0, wena=0, bus 'z, done=1 for one cycle, state IDLE.
//  - Read beat (2 cycles): READ_REQ: ena=1, wena=0, addr=A (RAM loads output at next edge);
//    READ_CAP: ena=0 (RAM releases bus at following edge). At the edge leaving READ_CAP, sample
//    ram_data into rsp_rdata, rsp_addr=A, rsp_valid=1 for one cycle. Next beat goes
//    READ_REQ at A+1; the last beat goes IDLE with done=1 coincident with its rsp_valid.
//  - Read latency: accept E0 -> rsp_valid high in the cycle after E2. Beat k response after E(2k+2).
//  - Turnaround: ena is low in READ_CAP, so the RAM has released the bus before any master
//    drive. The master never drives the bus in READ_REQ/READ_CAP/IDLE. IDLE always keeps ena=0.
//  - Address arithmetic: ADDR_W-bit, modulo 2**ADDR_W. Wrap 31->0 is legal and silent.
//  - Beat counter: ADDR_W bits, loaded with req_len, decrements per beat; last beat when 0.
//  - No response backpressure: the consumer must take every rsp_valid strobe.
//  - done never asserts without a preceding accepted request. No done after a reset abort.
// TESTING
//  1 reset: assert rst_n=0 mid-cycle -> all outputs at reset values immediately, ram_data=z,
//    req_ready=1 after release.
//  2 single write A=5, D=32'hDEADBEEF, len=0 -> one WRITE cycle, RAM[5]=DEADBEEF, done 1 cycle;
//    then read A=5 -> rsp_valid after E2, rsp_rdata=DEADBEEF, rsp_addr=5.
//  3 fill wrap: write A=30, len=3, D=32'hA5A5A5A5 -> RAM[30],[31],[0],[1]=A5A5A5A5, RAM[2] unchanged,
//    4 write cycles then done.
//  4 full read: preload RAM[i]=i, read A=0, len=31 -> 32 rsp strobes 2 cycles apart,
//    rsp_rdata=rsp_addr=0..31, done with the 32nd.
//  5 read then immediate write (req_valid held high) -> ram_data never X/contended,
//    ena=0 in between, write lands correctly.
//  6 reset mid read burst (after 3rd rsp) -> no further rsp_valid/done;
//    new single read after reset returns correct data.

Source files
------------

// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if: request/response port and RAM control lines of the RAM bus master.
// The tri-state data bus stays a plain inout on the master so it resolves at the top level.
interface ram_bus_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;
    logic              done;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr, done, ram_ena, ram_wena, ram_addr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr, done, ram_ena, ram_wena, ram_addr
    );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master: sequences single/burst reads and fill-writes onto a single-port tri-state RAM.
// Every RAM-side signal, including the bus drive enable, comes straight from a flop.
module ram_bus_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_bus_master_if.master   bus,
    inout  wire  [DATA_W-1:0]  ram_data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_CAP} state_t;

    state_t            state_q, state_d;
    logic              ena_q, ena_d;
    logic              wena_q, wena_d;
    logic              drive_q, drive_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        ena_d       = 1'b0;
        wena_d      = 1'b0;
        drive_d     = 1'b0;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    wdata_d = bus.req_wdata;
                    ena_d   = 1'b1;
                    wena_d  = bus.req_write;
                    drive_d = bus.req_write;
                    state_d = bus.req_write ? WRITE : READ_REQ;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    ena_d   = 1'b1;
                    wena_d  = 1'b1;
                    drive_d = 1'b1;
                end
            end
            READ_REQ: state_d = READ_CAP;
            default: begin
                // ena is already low here, so the RAM lets go of the bus at this same edge
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_data;
                rsp_addr_d  = addr_q;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ_REQ;
                    cnt_d   = cnt_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    ena_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ena_q       <= 1'b0;
            wena_q      <= 1'b0;
            drive_q     <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ena_q       <= ena_d;
            wena_q      <= wena_d;
            drive_q     <= drive_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            done_q      <= done_d;
        end
    end

    assign ram_data      = drive_q ? wdata_q : 'z;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.ram_ena   = ena_q;
    assign bus.ram_wena  = wena_q;
    assign bus.ram_addr  = addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: random and directed bursts against a tri-state RAM model and a
// cycle-indexed expectation table built from the burst timing rules.
module tb_ram_bus_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  [31:0] ram_data;

    ram_bus_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    ram_bus_master #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [32];
    logic [31:0] ram_dout;
    logic        ram_oe;
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wena) ram_mem[bus.ram_addr] <= ram_data;
        if (bus.ram_ena && !bus.ram_wena) ram_dout <= ram_mem[bus.ram_addr];
        ram_oe <= bus.ram_ena && !bus.ram_wena;
    end
    assign ram_data = ram_oe ? ram_dout : 'z;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int done_cnt = 0;
    logic [31:0] last_rdata;
    logic [4:0]  last_raddr;
    logic [31:0] model_mem [32];

    bit          exp_busy [int];
    bit          exp_ena [int];
    bit          exp_wena [int];
    logic [4:0]  exp_addr [int];
    logic [31:0] exp_wd [int];
    logic [31:0] exp_rdata [int];
    logic [4:0]  exp_raddr [int];
    bit          exp_done [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Accept at the edge ending cycle n: cycle n+1+k is the k-th cycle after that edge.
    function automatic void add_req(input int n, input bit w, input int a, input int l, input logic [31:0] d);
        for (int k = 0; k <= l; k++) begin
            int ad = (a + k) % 32;
            if (w) begin
                exp_ena[n + 1 + k] = 1;
                exp_wena[n + 1 + k] = 1;
                exp_addr[n + 1 + k] = 5'(ad);
                exp_wd[n + 1 + k] = d;
                exp_busy[n + 1 + k] = 1;
                model_mem[ad] = d;
            end else begin
                exp_ena[n + 1 + 2 * k] = 1;
                exp_addr[n + 1 + 2 * k] = 5'(ad);
                exp_busy[n + 1 + 2 * k] = 1;
                exp_busy[n + 2 + 2 * k] = 1;
                exp_rdata[n + 3 + 2 * k] = model_mem[ad];
                exp_raddr[n + 3 + 2 * k] = 5'(ad);
            end
        end
        exp_done[w ? n + l + 2 : n + 2 * l + 3] = 1;
    endfunction

    function automatic void clear_exp();
        exp_busy.delete();
        exp_ena.delete();
        exp_wena.delete();
        exp_addr.delete();
        exp_wd.delete();
        exp_rdata.delete();
        exp_raddr.delete();
        exp_done.delete();
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.req_valid && bus.req_ready)
            add_req(cyc, bus.req_write, int'(bus.req_addr), int'(bus.req_len), bus.req_wdata);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", bus.req_ready, !exp_busy.exists(cyc));
            chk("ram_ena", bus.ram_ena, exp_ena.exists(cyc));
            chk("ram_wena", bus.ram_wena, exp_wena.exists(cyc));
            if (exp_ena.exists(cyc)) chk("ram_addr", bus.ram_addr, exp_addr[cyc]);
            chk("bus_drive", dut.drive_q, exp_wena.exists(cyc));
            chk("bus_contention", dut.drive_q & ram_oe, 0);
            if (exp_wena.exists(cyc)) chk("bus_wdata", ram_data, exp_wd[cyc]);
            chk("rsp_valid", bus.rsp_valid, exp_rdata.exists(cyc));
            if (exp_rdata.exists(cyc)) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata[cyc]);
                chk("rsp_addr", bus.rsp_addr, exp_raddr[cyc]);
            end
            chk("done", bus.done, exp_done.exists(cyc));
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rdata = bus.rsp_rdata;
                last_raddr = bus.rsp_addr;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic do_req(input bit w, input int a, input int l, input logic [31:0] d, input bit hold);
        bit ok = 0;
        @(negedge clk);
        bus.req_write = w;
        bus.req_addr  = 5'(a);
        bus.req_len   = 5'(l);
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", ok, 1);
        if (ok) @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (done_cnt > d0) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
    endtask

    task automatic check_reset_values();
        chk("rst_ena", bus.ram_ena, 0);
        chk("rst_wena", bus.ram_wena, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_drive", dut.drive_q, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_addr", bus.rsp_addr, 0);
        chk("rst_done", bus.done, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp();
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.req_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            ram_mem[i]   = 32'h1000 + i;
            model_mem[i] = 32'h1000 + i;
        end
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", bus.req_ready, 1);
        do_reset();

        do_req(1, 5, 0, 32'hDEADBEEF, 0);
        wait_done();
        chk("wr5_mem", ram_mem[5], 32'hDEADBEEF);
        r0 = rsp_cnt;
        do_req(0, 5, 0, 0, 0);
        wait_done();
        chk("rd5_count", rsp_cnt - r0, 1);
        chk("rd5_data", last_rdata, 32'hDEADBEEF);
        chk("rd5_addr", last_raddr, 5);

        do_req(1, 30, 3, 32'hA5A5A5A5, 0);
        wait_done();
        chk("wrap_30", ram_mem[30], 32'hA5A5A5A5);
        chk("wrap_31", ram_mem[31], 32'hA5A5A5A5);
        chk("wrap_0", ram_mem[0], 32'hA5A5A5A5);
        chk("wrap_1", ram_mem[1], 32'hA5A5A5A5);
        chk("wrap_2_untouched", ram_mem[2], 32'h1002);

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            ram_mem[i]   = i;
            model_mem[i] = i;
        end
        r0 = rsp_cnt;
        do_req(0, 0, 31, 0, 0);
        wait_done();
        chk("full_count", rsp_cnt - r0, 32);
        chk("full_last_addr", last_raddr, 31);
        chk("full_last_data", last_rdata, 31);

        do_req(0, 3, 0, 0, 1);
        do_req(1, 10, 1, 32'hCAFEF00D, 0);
        wait_done();
        chk("rw_read_data", last_rdata, 3);
        chk("rw_mem10", ram_mem[10], 32'hCAFEF00D);
        chk("rw_mem11", ram_mem[11], 32'hCAFEF00D);
        chk("rw_mem12", ram_mem[12], 12);

        r0 = rsp_cnt;
        do_req(0, 0, 31, 0, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (rsp_cnt >= r0 + 3) break;
        end
        chk("abort_three_rsp", rsp_cnt - r0, 3);
        do_reset();
        r0 = rsp_cnt;
        d0 = done_cnt;
        repeat (80) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        do_req(0, 7, 0, 0, 0);
        wait_done();
        chk("after_abort_data", last_rdata, 7);
        chk("after_abort_addr", last_raddr, 7);

        for (int t = 0; t < 30; t++) begin
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 6)), $urandom, 0);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 32; i++) chk("final_mem", ram_mem[i], model_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
